// File: rtl/router_reg_pkt.sv
// router_reg_pkt: router input-stage byte register with hold stall, parity/length accounting and error flags.
module router_reg_pkt #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int NUM_PORTS = 3,
  parameter int PARITY_ODD = 0,
  parameter int LEN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              parity_err,
  output logic              len_err,
  output logic              addr_err
);
  localparam int CW = DATA_W - ADDR_W + 1;
  localparam logic [DATA_W-1:0] PMASK = (PARITY_ODD != 0) ? '1 : '0;
  logic [DATA_W-1:0] header_q, hold_q, ip, pp;
  logic [CW-1:0] pc, len;
  logic hold_v, hold_pay, addr_ok, ld_go, laf_go, pay_ld, pay_laf, par_ld, par_laf, clr;
  always_comb begin
    addr_ok = 32'(data_in[ADDR_W-1:0]) < NUM_PORTS;
    len     = CW'(header_q[DATA_W-1:ADDR_W]);
    ld_go   = ld_state & ~fifo_full;
    laf_go  = laf_state & hold_v;
    pay_ld  = ld_go & pkt_valid;
    pay_laf = laf_go & hold_pay;
    par_ld  = ld_go & ~pkt_valid;
    par_laf = laf_go & ~hold_pay;
    clr     = detect_add | rst_int_reg;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      header_q <= '0;
      hold_q   <= '0;
      hold_v   <= 1'b0;
      hold_pay <= 1'b0;
      addr_err <= 1'b0;
      dout     <= '0;
      dout_valid <= 1'b0;
    end else begin
      addr_err <= detect_add & pkt_valid & ~addr_ok;
      if (detect_add & pkt_valid & addr_ok) header_q <= data_in;
      if (detect_add) hold_v <= 1'b0;
      else if (ld_state & fifo_full) begin
        hold_q   <= data_in;
        hold_v   <= 1'b1;
        hold_pay <= pkt_valid;
      end else if (laf_state) hold_v <= 1'b0;
      dout_valid <= lfd_state | ld_go | laf_go;
      if (lfd_state) dout <= header_q;
      else if (ld_go) dout <= data_in;
      else if (laf_go) dout <= hold_q;
    end
  end
  // Per-packet accounting; the parity byte itself never enters ip or pc.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      ip <= '0;
      pc <= '0;
      pp <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
    end else begin
      ip <= ip ^ (lfd_state ? header_q : '0) ^ (pay_ld ? data_in : '0) ^ (pay_laf ? hold_q : '0);
      if ((pay_ld | pay_laf) && !(&pc)) pc <= pc + 1'b1;
      if ((par_ld | par_laf) && !parity_done) begin
        pp <= par_ld ? data_in : hold_q;
        parity_done <= 1'b1;
      end
      if (ld_state & ~pkt_valid) low_pkt_valid <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_err <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      parity_err <= parity_done & (pp != (ip ^ PMASK));
      len_err    <= (LEN_CHECK != 0) & parity_done & (pc != len);
    end
  end
endmodule
